// File: rtl/register_file_8x32.sv
// register_file_8x32: eight-entry general-purpose register file with two
// combinational read ports and one synchronous write port. r0 is hardwired
// to zero and has no storage.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).
module register_file_8x32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       read_addr1,
  input  logic [2:0]       read_addr2,
  input  logic [2:0]       write_addr,
  input  logic [WIDTH-1:0] write_data,
  input  logic             write_enable,
  output logic [WIDTH-1:0] read_data1,
  output logic [WIDTH-1:0] read_data2
);

  logic [WIDTH-1:0] regs_q [1:7];
  logic [WIDTH-1:0] regs_d [1:7];

  // Next-state: at most the one addressed register takes write_data; address 0 matches nothing
  always_comb begin
    for (int i = 1; i < 8; i++) begin
      regs_d[i] = regs_q[i];
      if (write_enable && (write_addr == 3'(i))) begin
        regs_d[i] = write_data;
      end
    end
  end

  // Storage update; synchronous reset wins over any write in the same cycle
  always_ff @(posedge clk) begin
    for (int i = 1; i < 8; i++) begin
      if (reset) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read port 1: stored value, zero for r0, optionally forwarded from the pending write
  always_comb begin
    read_data1 = '0;
    for (int i = 1; i < 8; i++) begin
      if (read_addr1 == 3'(i)) begin
        read_data1 = regs_q[i];
      end
    end
`ifdef REGFILE_BYPASS_EN
    if (write_enable && !reset && (write_addr != 3'd0) && (read_addr1 == write_addr)) begin
      read_data1 = write_data;
    end
`endif
  end

  // Read port 2: identical to port 1 but independently addressed
  always_comb begin
    read_data2 = '0;
    for (int i = 1; i < 8; i++) begin
      if (read_addr2 == 3'(i)) begin
        read_data2 = regs_q[i];
      end
    end
`ifdef REGFILE_BYPASS_EN
    if (write_enable && !reset && (write_addr != 3'd0) && (read_addr2 == write_addr)) begin
      read_data2 = write_data;
    end
`endif
  end

endmodule
